// File: rtl/adc_capture_ctrl.sv
// Triggered multi-channel ADC frame capture into per-channel circular RAMs.
// Optional DC_REMOVE_EN: stores DC-removed samples through one extra write stage.
module adc_capture_ctrl #(
    parameter int DATA_W   = 12,
    parameter int CH_NUM   = 2,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int TIMEOUT  = 1_000_000,
    parameter int DC_SHIFT = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adc_valid,
    input  logic [CH_NUM*DATA_W-1:0] adc_data,
    input  logic                     start,
    input  logic                     mode_cont,
    input  logic [CH_W-1:0]          trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic [ADDR_W-1:0]        pre_len,
    output logic                     busy,
    output logic                     data_ready,
    input  logic                     ext_ack,
    input  logic                     ext_read,
    input  logic [CH_W-1:0]          ext_ch,
    input  logic [ADDR_W-1:0]        ext_addr,
    output logic [DATA_W-1:0]        ext_data,
    output logic                     ext_valid,
    output logic [ADDR_W-1:0]        trig_addr,
    output logic                     overrun,
    output logic                     timeout_flag
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_POST, S_READY, S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                first_q, first_d;
    logic [ADDR_W-1:0]   pre_len_q, pre_len_d;
    logic [CH_W-1:0]     trig_ch_q, trig_ch_d;
    logic [DATA_W-1:0]   lvl_q, lvl_d;
    logic                cont_q, cont_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                dr_q, dr_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                ovr_q, ovr_d;
    logic                tflag_q, tflag_d;
    logic [DATA_W-1:0]   ext_data_q;
    logic                ext_valid_q;

    logic [DATA_W-1:0]   samp [CH_NUM];
    logic [DATA_W-1:0]   cur;
    logic [ADDR_W-1:0]   post_len;
    logic                we, last;
    logic                wen;
    logic [ADDR_W-1:0]   wadr;
    logic [DATA_W-1:0]   wdat [CH_NUM];
    logic [DATA_W-1:0]   mem [CH_NUM][DEPTH];
    logic [ADDR_W-1:0]   rd_addr;
    logic                ch_ok;

    always_comb begin
        cur = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            samp[c] = adc_data[c*DATA_W +: DATA_W];
            if (trig_ch_q == CH_W'(c)) cur = samp[c];
        end
    end

    assign post_len = ADDR_W'(DEPTH - 1) - pre_len_q;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        prev_d      = prev_q;
        first_d     = first_q;
        pre_len_d   = pre_len_q;
        trig_ch_d   = trig_ch_q;
        lvl_d       = lvl_q;
        cont_d      = cont_q;
        trig_addr_d = trig_addr_q;
        dr_d        = dr_q;
        tmo_d       = tmo_q;
        ovr_d       = ovr_q;
        tflag_d     = 1'b0;
        we          = 1'b0;
        last        = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_ARM;
                pre_cnt_d = '0;
                first_d   = 1'b1;
                ovr_d     = 1'b0;
                pre_len_d = pre_len;
                trig_ch_d = trig_ch;
                lvl_d     = trig_level;
                cont_d    = mode_cont;
            end
            S_ARM: begin
                if (start && !mode_cont) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    we      = 1'b1;
                    prev_d  = cur;
                    first_d = 1'b0;
                    if (pre_cnt_q < pre_len_q) pre_cnt_d = pre_cnt_q + 1'b1;
                    if (!first_q && prev_q < lvl_q && cur >= lvl_q
                        && pre_cnt_q >= pre_len_q) begin
                        trig_addr_d = wptr_q;
                        post_cnt_d  = post_len;
                        if (post_len == '0) last = 1'b1;
                        else state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (start && !mode_cont) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    we         = 1'b1;
                    prev_d     = cur;
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == ADDR_W'(1)) last = 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_READY;
                dr_d    = 1'b1;
                tmo_d   = '0;
            end
            S_READY: begin
                if (adc_valid) ovr_d = 1'b1;
                if (ext_ack || tmo_q == TW'(TIMEOUT - 1)) begin
                    dr_d    = 1'b0;
                    tflag_d = !ext_ack;
                    state_d = cont_q ? S_ARM : S_IDLE;
                    if (cont_q) begin
                        pre_cnt_d = '0;
                        first_d   = 1'b1;
                        pre_len_d = pre_len;
                        trig_ch_d = trig_ch;
                        lvl_d     = trig_level;
                        cont_d    = mode_cont;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // the final frame write must land in RAM before data_ready rises
        if (last) begin
`ifdef DC_REMOVE_EN
            state_d = S_FLUSH;
`else
            state_d = S_READY;
            dr_d    = 1'b1;
            tmo_d   = '0;
`endif
        end
        if (we) wptr_d = wptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            prev_q      <= '0;
            first_q     <= 1'b0;
            pre_len_q   <= '0;
            trig_ch_q   <= '0;
            lvl_q       <= '0;
            cont_q      <= 1'b0;
            trig_addr_q <= '0;
            dr_q        <= 1'b0;
            tmo_q       <= '0;
            ovr_q       <= 1'b0;
            tflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            prev_q      <= prev_d;
            first_q     <= first_d;
            pre_len_q   <= pre_len_d;
            trig_ch_q   <= trig_ch_d;
            lvl_q       <= lvl_d;
            cont_q      <= cont_d;
            trig_addr_q <= trig_addr_d;
            dr_q        <= dr_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
            tflag_q     <= tflag_d;
        end
    end

`ifdef DC_REMOVE_EN
    localparam int ACC_W = DATA_W + DC_SHIFT;
    logic              wen_q;
    logic [ADDR_W-1:0] wadr_q;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_dc
        logic [ACC_W-1:0]  acc_q;
        logic [DATA_W-1:0] res_q;
        logic [DATA_W-1:0] dcv;
        logic [DATA_W:0]   diff;
        assign dcv  = DATA_W'(acc_q >> DC_SHIFT);
        assign diff = {1'b0, samp[c]} - {1'b0, dcv};
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
                res_q <= '0;
            end else if (adc_valid) begin
                acc_q <= acc_q + ACC_W'(samp[c]) - ACC_W'(dcv);
                if (diff[DATA_W] == diff[DATA_W-1])
                    res_q <= diff[DATA_W-1:0];
                else if (diff[DATA_W])
                    res_q <= {1'b1, {(DATA_W-1){1'b0}}};
                else
                    res_q <= {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
        assign wdat[c] = res_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            wadr_q <= '0;
        end else begin
            wen_q  <= we;
            wadr_q <= wptr_q;
        end
    end

    assign wen  = wen_q;
    assign wadr = wadr_q;
`else
    assign wen  = we;
    assign wadr = wptr_q;
    assign wdat = samp;
`endif

    always_ff @(posedge clk) begin
        if (wen && rst_n)
            for (int c = 0; c < CH_NUM; c++) mem[c][wadr] <= wdat[c];
    end

    assign rd_addr = trig_addr_q - pre_len_q + ext_addr;
    assign ch_ok   = ({1'b0, ext_ch} < (CH_W + 1)'(CH_NUM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_valid_q <= 1'b0;
            ext_data_q  <= '0;
        end else begin
            ext_valid_q <= ext_read;
            if (ext_read)
                ext_data_q <= (dr_q && ch_ok) ? mem[ext_ch][rd_addr] : '0;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign data_ready   = dr_q;
    assign trig_addr    = trig_addr_q;
    assign overrun      = ovr_q;
    assign timeout_flag = tflag_q;
    assign ext_data     = ext_data_q;
    assign ext_valid    = ext_valid_q;

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Multi-channel, triggered frame-capture controller for the ADC front end. It stores parallel samples from CH_NUM channels into per-channel circular RAMs and arms on a host start. It detects a rising level-crossing trigger on a selectable channel and freezes a DEPTH-sample frame with a programmable pre-trigger length. It then hands the frame to the external reader through a data_ready/ext_ack handshake with timeout, in single-shot or continuous mode.

Parameters:
DATA_W, 12, sample width per channel
CH_NUM, 2, number of ADC channels
DEPTH, 1024, samples per channel per frame; power of two
ADDR_W, $clog2(DEPTH), address width
CH_W, (CH_NUM>1)?$clog2(CH_NUM):1, channel-select width
TIMEOUT, 1_000_000, cycles data_ready is held without ext_ack
DC_SHIFT, 10, DC-tracker time constant exponent (used only with DC_REMOVE_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
adc_valid  in  1  sample strobe, same clock domain
adc_data  in  CH_NUM*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
start  in  1  pulse: arm capture
mode_cont  in  1  1 = re-arm automatically after hand-off
trig_ch  in  CH_W  trigger source channel
trig_level  in  DATA_W  trigger threshold, unsigned raw
pre_len  in  ADDR_W  samples kept before trigger
busy  out  1  state != S_IDLE
data_ready  out  1  frame frozen and readable
ext_ack  in  1  reader done
ext_read  in  1  read request
ext_ch  in  CH_W  read channel
ext_addr  in  ADDR_W  frame-relative index; 0 = oldest sample
ext_data  out  DATA_W  read data
ext_valid  out  1  ext_data valid
trig_addr  out  ADDR_W  absolute RAM address of the trigger sample
overrun  out  1  sticky: adc_valid seen in S_READY
timeout_flag  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state S_IDLE. busy, data_ready, ext_valid, overrun, timeout_flag = 0. ext_data = 0, trig_addr = 0. Write pointer, counters and prev-sample registers = 0. RAM contents are not reset.
- Register config: pre_len, trig_ch, trig_level and mode_cont are captured on an accepted start, and again on auto re-arm. Changes while busy have no effect.
- S_IDLE: start -> S_ARM, pre_cnt = 0, overrun cleared.
- S_ARM: each adc_valid writes all channels at wptr, then wptr++ mod DEPTH and pre_cnt increments, saturating at pre_len.
  - Trigger condition: prev < trig_level && cur >= trig_level on the latched channel, with pre_cnt >= pre_len before this sample.
  - On trigger: trig_addr = write address of the trigger sample; post_cnt = DEPTH - pre_len - 1; go to S_POST. If post_cnt = 0, go directly to S_READY.
  - prev updates on every adc_valid in S_ARM and S_POST. After start, the first sample only loads prev and cannot trigger.
- S_POST: each adc_valid writes and decrements post_cnt. The write that takes post_cnt to 0 moves to S_READY; data_ready = 1 on the next cycle. Frame start address = trig_addr - pre_len mod DEPTH.
- S_READY: no writes. adc_valid sets overrun.
  - ext_read: ext_data = RAM[ext_ch][(frame_start + ext_addr) mod DEPTH]. Latency 1 cycle; ext_valid pulses 1 cycle. Back-to-back reads are allowed.
  - ext_read while data_ready = 0 returns ext_valid = 1 with ext_data = 0.
  - Timeout counter starts at 0 on entry. ext_ack, or the counter reaching TIMEOUT-1, clears data_ready. On timeout, timeout_flag pulses.
  - Exit target: mode_cont = 1 -> S_ARM with pre_cnt reset. Otherwise -> S_IDLE.
  - If ext_ack and timeout occur in the same cycle, ext_ack wins and no timeout_flag is raised.
- Ignored inputs: start outside S_IDLE; ext_ack outside S_READY.
- Abort: start with mode_cont = 0 while in S_ARM or S_POST returns to S_IDLE the next cycle with no frame.
- ext_ch >= CH_NUM: ext_data = 0.
- Reset asserted mid-operation: synchronous return to reset values on the next edge.

Optional Feature:
DC_REMOVE_EN
- Defined: a per-channel accumulator of DATA_W+DC_SHIFT bits updates on adc_valid: acc += x - (acc >> DC_SHIFT).
  - Stored sample = x - (acc >> DC_SHIFT), saturated to signed DATA_W, two's complement.
  - The trigger still uses raw data.
  - Adds one pipeline stage between adc_valid and the RAM write; trig_addr stays aligned with the trigger sample.
  - Accumulators reset to 0 and keep running in every state.
- Undefined: raw unsigned samples are stored with no added latency.

Test Plan:
- DEPTH=16, pre_len=4, ramp 0..255 on ch0, trig_level=100, start -> trigger at sample value 100. Frame ext_addr 0..15 reads 96..111; data_ready rises one cycle after the last post write.
- Trigger already above level at start (ch0 constant 200) -> no trigger; busy stays 1. A drop to 50 then rise to 150 triggers.
- mode_cont=1, frame ready, pulse ext_ack -> data_ready falls next cycle. State returns to S_ARM and a second frame captures with new trig_addr.
- TIMEOUT=8, no ext_ack -> data_ready high exactly 8 cycles, then timeout_flag pulses once and state returns to S_IDLE.
- adc_valid during S_READY -> overrun=1 and RAM is unchanged; next start clears overrun.
- DC_REMOVE_EN, DC_SHIFT=4, constant 2048 input for 200 samples -> stored samples converge to 0 within ±1.
